ibuf_col_pingpong: RTL and testbench

- Parametrised next-generation column input buffer feeding one systolic MAC-array row/column lane.
- Accepts packed words of LEN elements over a valid/ready handshake into two ping-pong banks.
- Serialises elements most-significant first, one per ShiftEN, and forwards a registered ShiftEN to the next PE.
- The second bank fills while the first drains, so back-to-back words stream with no bubble.

---
 rtl/ibuf_pkg.sv | 16 +
 rtl/ibuf_bank.sv | 38 +++
 rtl/ibuf_col_pingpong.sv | 163 ++++++++++++++++
 tb/tb_ibuf_col_pingpong.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibuf_pkg.sv
// Shared definitions for the column input buffer: default sizes and occupancy encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ibuf_pkg;

    localparam int DW_DEF  = 8;
    localparam int LEN_DEF = 4;

    // Occupancy of the two ping-pong banks, decoded from the bank-full flags.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_t;

endpackage

// File: rtl/ibuf_bank.sv
// One LEN x DW element bank: parallel load of a packed word, indexed element read.
// Latency: write visible one cycle after we; read is combinational from ridx.
// Backpressure: none; the owner decides when a write is allowed.
//
// Ports: CLK/RSTN clock and async active-low reset; we loads wdata (element 0 in the
// most-significant DW bits); ridx selects the element presented on rdata.
module ibuf_bank
    import ibuf_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int LEN  = LEN_DEF,
    parameter int IDXW = $clog2(LEN)
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                we,
    input  logic [DW*LEN-1:0]   wdata,
    input  logic [IDXW-1:0]     ridx,
    output logic [DW-1:0]       rdata
);

    logic [DW-1:0] mem [LEN];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < LEN; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < LEN; i++) begin
                mem[i] <= wdata[DW*LEN-1-DW*i -: DW];
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/ibuf_col_pingpong.sv
// Ping-pong column input buffer: packed words in, elements out MSB-first, one per ShiftEN.
// Latency: first element on OD two cycles after accept when ShiftEN follows the accept.
// Backpressure: IReady low only while both banks hold unread words.
//
// Ports: CLK, RSTN (async active-low), CLR (sync flush); IWord/IValid/IReady input
// handshake; ShiftEN pops one element; OD/OValid/OLast registered element output;
// ShiftEN_o is ShiftEN delayed one cycle; Empty when no bank holds a word.
// Optional macro IBUF_UNDERRUN_CNT_EN adds UnderrunCnt, a saturating count of pops
// requested while empty, cleared by RSTN and CLR.
module ibuf_col_pingpong
    import ibuf_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int LEN = LEN_DEF
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                CLR,
    input  logic [DW*LEN-1:0]   IWord,
    input  logic                IValid,
    output logic                IReady,
    input  logic                ShiftEN,
    output logic [DW-1:0]       OD,
    output logic                OValid,
    output logic                OLast,
    output logic                ShiftEN_o,
    output logic                Empty
`ifdef IBUF_UNDERRUN_CNT_EN
    ,
    output logic [15:0]         UnderrunCnt
`endif
);

    localparam int IDXW = $clog2(LEN);

    logic [1:0]      full_q, full_d;
    logic            rd_bank_q, rd_bank_d;
    logic            wr_bank_q, wr_bank_d;
    logic [IDXW-1:0] idx_q, idx_d;
    occ_state_t      state;
    logic            accept, pop, last_el;
    logic [DW-1:0]   rdata0, rdata1, rdata;

    // Banks fill and drain in the same order, so a single full bank is always rd_bank.
    always_comb begin
        state = ST_EMPTY;
        if (full_q == 2'b11) begin
            state = ST_TWO;
        end else if (full_q != 2'b00) begin
            state = ST_ONE;
        end
    end

    assign IReady  = (state != ST_TWO);
    assign Empty   = (state == ST_EMPTY);
    assign accept  = IValid && IReady;
    assign pop     = ShiftEN && full_q[rd_bank_q];
    assign last_el = (idx_q == IDXW'(LEN - 1));
    assign rdata   = rd_bank_q ? rdata1 : rdata0;

    ibuf_bank #(.DW(DW), .LEN(LEN), .IDXW(IDXW)) u_bank0 (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .we    (accept && !CLR && !wr_bank_q),
        .wdata (IWord),
        .ridx  (idx_q),
        .rdata (rdata0)
    );

    ibuf_bank #(.DW(DW), .LEN(LEN), .IDXW(IDXW)) u_bank1 (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .we    (accept && !CLR && wr_bank_q),
        .wdata (IWord),
        .ridx  (idx_q),
        .rdata (rdata1)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            full_q    <= 2'b00;
            rd_bank_q <= 1'b0;
            wr_bank_q <= 1'b0;
            idx_q     <= '0;
        end else begin
            full_q    <= full_d;
            rd_bank_q <= rd_bank_d;
            wr_bank_q <= wr_bank_d;
            idx_q     <= idx_d;
        end
    end

    // Accept and pop never target the same bank: wr_bank==rd_bank only in EMPTY
    // (no pop) or TWO (no accept), so both updates may apply in one cycle.
    always_comb begin
        full_d    = full_q;
        rd_bank_d = rd_bank_q;
        wr_bank_d = wr_bank_q;
        idx_d     = idx_q;
        if (CLR) begin
            full_d    = 2'b00;
            rd_bank_d = 1'b0;
            wr_bank_d = 1'b0;
            idx_d     = '0;
        end else begin
            if (pop) begin
                if (last_el) begin
                    idx_d             = '0;
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            if (accept) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            OD        <= '0;
            OValid    <= 1'b0;
            OLast     <= 1'b0;
            ShiftEN_o <= 1'b0;
        end else begin
            ShiftEN_o <= ShiftEN;
            if (CLR) begin
                OValid <= 1'b0;
                OLast  <= 1'b0;
            end else if (pop) begin
                OD     <= rdata;
                OValid <= 1'b1;
                OLast  <= last_el;
            end else begin
                OValid <= 1'b0;
                OLast  <= 1'b0;
                // Underrun drives a zero element so the PE sees no stale data.
                if (ShiftEN) begin
                    OD <= '0;
                end
            end
        end
    end

`ifdef IBUF_UNDERRUN_CNT_EN
    logic underrun;
    assign underrun = ShiftEN && !pop;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            UnderrunCnt <= 16'h0000;
        end else if (CLR) begin
            UnderrunCnt <= 16'h0000;
        end else if (underrun && (UnderrunCnt != 16'hFFFF)) begin
            UnderrunCnt <= UnderrunCnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_ibuf_col_pingpong.sv
// Directed bench for ibuf_col_pingpong at LEN=4/DW=8 plus a LEN=8/DW=16 instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_ibuf_col_pingpong;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        CLR;
    logic [31:0] IWord;
    logic        IValid;
    logic        IReady;
    logic        ShiftEN;
    logic [7:0]  OD;
    logic        OValid;
    logic        OLast;
    logic        ShiftEN_o;
    logic        Empty;

    logic         clr8;
    logic [127:0] iword8;
    logic         ivalid8;
    logic         iready8;
    logic         shift8;
    logic [15:0]  od8;
    logic         ovalid8;
    logic         olast8;
    logic         shift8_o;
    logic         empty8;

`ifdef IBUF_UNDERRUN_CNT_EN
    logic [15:0] UnderrunCnt;
    logic [15:0] ucnt8;
`endif

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    ibuf_col_pingpong #(.DW(8), .LEN(4)) u_dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .CLR       (CLR),
        .IWord     (IWord),
        .IValid    (IValid),
        .IReady    (IReady),
        .ShiftEN   (ShiftEN),
        .OD        (OD),
        .OValid    (OValid),
        .OLast     (OLast),
        .ShiftEN_o (ShiftEN_o),
        .Empty     (Empty)
`ifdef IBUF_UNDERRUN_CNT_EN
        ,
        .UnderrunCnt (UnderrunCnt)
`endif
    );

    ibuf_col_pingpong #(.DW(16), .LEN(8)) u_dut8 (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .CLR       (clr8),
        .IWord     (iword8),
        .IValid    (ivalid8),
        .IReady    (iready8),
        .ShiftEN   (shift8),
        .OD        (od8),
        .OValid    (ovalid8),
        .OLast     (olast8),
        .ShiftEN_o (shift8_o),
        .Empty     (empty8)
`ifdef IBUF_UNDERRUN_CNT_EN
        ,
        .UnderrunCnt (ucnt8)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RSTN    = 1'b0;
        CLR     = 1'b0;
        IWord   = '0;
        IValid  = 1'b0;
        ShiftEN = 1'b0;
        clr8    = 1'b0;
        iword8  = '0;
        ivalid8 = 1'b0;
        shift8  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // Reset state
        check("rst_od",     32'(OD),        0);
        check("rst_ovalid", 32'(OValid),    0);
        check("rst_olast",  32'(OLast),     0);
        check("rst_sheno",  32'(ShiftEN_o), 0);
        check("rst_empty",  32'(Empty),     1);
        check("rst_iready", 32'(IReady),    1);
        RSTN = 1'b1;
        tick();

        // Reset mid-drain
        IWord = 32'hA1B2C3D4; IValid = 1'b1;
        tick();
        IValid = 1'b0; ShiftEN = 1'b1;
        tick();
        check("mid_od0", 32'(OD), 32'hA1);
        tick();
        check("mid_od1", 32'(OD), 32'hB2);
        ShiftEN = 1'b0;
        #1 RSTN = 1'b0;
        #1;
        check("mid_rst_od",     32'(OD),        0);
        check("mid_rst_ovalid", 32'(OValid),    0);
        check("mid_rst_sheno",  32'(ShiftEN_o), 0);
        check("mid_rst_empty",  32'(Empty),     1);
        check("mid_rst_iready", 32'(IReady),    1);
        RSTN = 1'b1;
        tick();

        // Single word after reset: drains from A1
        IWord = 32'hA1B2C3D4; IValid = 1'b1;
        tick();
        IValid = 1'b0; ShiftEN = 1'b1;
        tick();
        check("sw_od0", 32'(OD), 32'hA1); check("sw_v0", 32'(OValid), 1); check("sw_l0", 32'(OLast), 0);
        tick();
        check("sw_od1", 32'(OD), 32'hB2); check("sw_v1", 32'(OValid), 1); check("sw_l1", 32'(OLast), 0);
        tick();
        check("sw_od2", 32'(OD), 32'hC3); check("sw_v2", 32'(OValid), 1); check("sw_l2", 32'(OLast), 0);
        tick();
        check("sw_od3", 32'(OD), 32'hD4); check("sw_v3", 32'(OValid), 1); check("sw_l3", 32'(OLast), 1);
        ShiftEN = 1'b0;
        tick();
        check("sw_hold_od", 32'(OD),     32'hD4);
        check("sw_idle_v",  32'(OValid), 0);
        check("sw_idle_l",  32'(OLast),  0);
        check("sw_empty",   32'(Empty),  1);

        // Back-to-back words, no bubble
        IWord = 32'h01020304; IValid = 1'b1;
        tick();
        check("b2b_one_iready", 32'(IReady), 1);
        IWord = 32'h05060708;
        tick();
        check("b2b_two_iready", 32'(IReady), 0);
        IValid = 1'b0; ShiftEN = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("b2b_od",     32'(OD),     k);
            check("b2b_ovalid", 32'(OValid), 1);
            check("b2b_olast",  32'(OLast),  (k == 4 || k == 8) ? 1 : 0);
            check("b2b_iready", 32'(IReady), (k >= 4) ? 1 : 0);
        end
        ShiftEN = 1'b0;
        tick();
        check("b2b_end_sheno", 32'(ShiftEN_o), 0);
        check("b2b_end_od",    32'(OD),        32'h08);

        // Underrun for three cycles
        ShiftEN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ur_od",     32'(OD),        0);
            check("ur_ovalid", 32'(OValid),    0);
            check("ur_sheno",  32'(ShiftEN_o), 1);
        end
        ShiftEN = 1'b0;
        tick();
        check("ur_sheno_off", 32'(ShiftEN_o), 0);
`ifdef IBUF_UNDERRUN_CNT_EN
        check("ur_cnt", 32'(UnderrunCnt), 3);
`endif

        // Accept together with the last pop in ONE
        IWord = 32'hE1E2E3E4; IValid = 1'b1;
        tick();
        IValid = 1'b0; ShiftEN = 1'b1;
        tick();
        check("sim_od0", 32'(OD), 32'hE1);
        tick();
        check("sim_od1", 32'(OD), 32'hE2);
        tick();
        check("sim_od2", 32'(OD), 32'hE3);
        IWord = 32'h11223344; IValid = 1'b1;
        tick();
        IValid = 1'b0;
        check("sim_od3",    32'(OD),     32'hE4);
        check("sim_l3",     32'(OLast),  1);
        check("sim_empty",  32'(Empty),  0);
        check("sim_iready", 32'(IReady), 1);
        tick();
        check("sim_n0", 32'(OD), 32'h11); check("sim_nv0", 32'(OValid), 1);
        tick();
        check("sim_n1", 32'(OD), 32'h22); check("sim_nv1", 32'(OValid), 1);
        tick();
        check("sim_n2", 32'(OD), 32'h33); check("sim_nv2", 32'(OValid), 1);
        tick();
        check("sim_n3", 32'(OD), 32'h44); check("sim_nl3", 32'(OLast), 1);
        check("sim_end_empty", 32'(Empty), 1);
        ShiftEN = 1'b0;
        tick();

        // CLR in TWO, with ShiftEN held through the flush
        IWord = 32'h01020304; IValid = 1'b1;
        tick();
        IWord = 32'h05060708;
        tick();
        IValid = 1'b0; ShiftEN = 1'b1;
        tick();
        check("clr_pre_od", 32'(OD),     32'h01);
        check("clr_pre_rdy", 32'(IReady), 0);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        check("clr_empty",  32'(Empty),     1);
        check("clr_iready", 32'(IReady),    1);
        check("clr_ovalid", 32'(OValid),    0);
        check("clr_od",     32'(OD),        32'h01);
        check("clr_sheno",  32'(ShiftEN_o), 1);
`ifdef IBUF_UNDERRUN_CNT_EN
        check("clr_cnt", 32'(UnderrunCnt), 0);
`endif
        tick();
        check("clr_ur_od",     32'(OD),     0);
        check("clr_ur_ovalid", 32'(OValid), 0);
`ifdef IBUF_UNDERRUN_CNT_EN
        check("clr_ur_cnt", 32'(UnderrunCnt), 1);
`endif
        ShiftEN = 1'b0;
        tick();

        // LEN=8, DW=16 instance: OLast on element 7 only
        for (int i = 0; i < 8; i++) begin
            iword8[127-16*i -: 16] = 16'(16'h1000 + i);
        end
        ivalid8 = 1'b1;
        tick();
        ivalid8 = 1'b0; shift8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("l8_od",     32'(od8),     32'h1000 + i);
            check("l8_ovalid", 32'(ovalid8), 1);
            check("l8_olast",  32'(olast8),  (i == 7) ? 1 : 0);
        end
        shift8 = 1'b0;
        tick();
        check("l8_empty", 32'(empty8), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
